// File: rtl/mvp_seq_if.sv
// mvp_seq_if: command, plane-memory, mvp and result signals of the precision sequencer
interface mvp_seq_if #(
    parameter int N    = 64,
    parameter int AW   = 10,
    parameter int ACCW = 24
);
    localparam int A = $clog2(N);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_wprec;
    logic [3:0]        cmd_iprec;
    logic [AW-1:0]     cmd_wbase;
    logic [AW-1:0]     cmd_dbase;
    logic              cmd_wsigned;
    logic              cmd_dsigned;
    logic [1:0]        cmd_mode;
    logic              w_rd_en;
    logic [AW-1:0]     w_addr;
    logic              d_rd_en;
    logic [AW-1:0]     d_addr;
    logic [1:0]        mvp_mode;
    logic [N*(A+2)-1:0] mvp_s;
    logic              res_valid;
    logic              res_ready;
    logic [N*ACCW-1:0] res_data;

    modport slave (
        input  cmd_valid, cmd_wprec, cmd_iprec, cmd_wbase, cmd_dbase,
               cmd_wsigned, cmd_dsigned, cmd_mode, mvp_s, res_ready,
        output cmd_ready, w_rd_en, w_addr, d_rd_en, d_addr, mvp_mode,
               res_valid, res_data
    );

    modport master (
        output cmd_valid, cmd_wprec, cmd_iprec, cmd_wbase, cmd_dbase,
               cmd_wsigned, cmd_dsigned, cmd_mode, mvp_s, res_ready,
        input  cmd_ready, w_rd_en, w_addr, d_rd_en, d_addr, mvp_mode,
               res_valid, res_data
    );
endinterface

// File: rtl/mvp_seq.sv
// mvp_seq: walks every (weight plane, data plane) pair through mvp and accumulates shifted, signed row sums
module mvp_seq #(
    parameter int N    = 64,
    parameter int PR   = 0,
    parameter int AW   = 10,
    parameter int ACCW = 24
) (
    input logic     clk,
    input logic     rst_n,
    mvp_seq_if.slave bus
);
    localparam int A  = $clog2(N);
    localparam int SW = A + 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    typedef struct packed {
        logic       v;
        logic [3:0] sh;
        logic       neg;
    } tag_t;

    state_t        state;
    logic [3:0]    wprec, iprec, wb, db, cw, ci, wp_n, ip_n, nwb, ndb;
    logic [AW-1:0] wbase, dbase, wbase_n, dbase_n;
    logic          wsigned, dsigned, ws_n, ds_n, accept, issue, busy;
    tag_t          ntag;
    tag_t          tp [PR+2];

    function automatic logic [3:0] sat(input logic [3:0] p);
        return p == 4'd0 ? 4'd1 : p > 4'd8 ? 4'd8 : p;
    endfunction

    function automatic logic [ACCW-1:0] term(input logic [SW-1:0] s, input logic [3:0] sh);
        return {{(ACCW-SW){s[SW-1]}}, s} << sh;
    endfunction

    // Next pair to issue: the first pair comes straight from the command so reads start the cycle after acceptance
    always_comb begin
        accept  = bus.cmd_ready && bus.cmd_valid;
        cw      = sat(bus.cmd_wprec);
        ci      = sat(bus.cmd_iprec);
        wp_n    = accept ? cw : wprec;
        ip_n    = accept ? ci : iprec;
        wbase_n = accept ? bus.cmd_wbase : wbase;
        dbase_n = accept ? bus.cmd_dbase : dbase;
        ws_n    = accept ? bus.cmd_wsigned : wsigned;
        ds_n    = accept ? bus.cmd_dsigned : dsigned;
        issue   = accept || (state == RUN && (wb != 4'd0 || db != 4'd0));
        nwb     = accept ? cw - 4'd1 : db == 4'd0 ? wb - 4'd1 : wb;
        ndb     = accept ? ci - 4'd1 : db == 4'd0 ? iprec - 4'd1 : db - 4'd1;
        ntag.v   = issue;
        ntag.sh  = nwb + ndb;
        ntag.neg = (ws_n && nwb == wp_n - 4'd1) ^ (ds_n && ndb == ip_n - 4'd1);
        busy = 1'b0;
        for (int k = 0; k <= PR; k++) busy = busy | tp[k].v;
    end

    // Control FSM with registered read strobes, addresses and handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.cmd_ready <= 1'b1;
            bus.res_valid <= 1'b0;
            bus.w_rd_en   <= 1'b0;
            bus.d_rd_en   <= 1'b0;
            bus.w_addr    <= '0;
            bus.d_addr    <= '0;
            bus.mvp_mode  <= '0;
            wprec         <= 4'd1;
            iprec         <= 4'd1;
            wbase         <= '0;
            dbase         <= '0;
            wsigned       <= 1'b0;
            dsigned       <= 1'b0;
            wb            <= '0;
            db            <= '0;
        end else begin
            bus.w_rd_en <= issue;
            bus.d_rd_en <= issue;
            if (issue) begin
                wb         <= nwb;
                db         <= ndb;
                bus.w_addr <= wbase_n + AW'(nwb);
                bus.d_addr <= dbase_n + AW'(ndb);
            end
            case (state)
                IDLE: if (accept) begin
                    state         <= RUN;
                    bus.cmd_ready <= 1'b0;
                    bus.mvp_mode  <= bus.cmd_mode;
                    wprec         <= cw;
                    iprec         <= ci;
                    wbase         <= bus.cmd_wbase;
                    dbase         <= bus.cmd_dbase;
                    wsigned       <= bus.cmd_wsigned;
                    dsigned       <= bus.cmd_dsigned;
                end
                RUN: if (!issue) state <= DRAIN;
                DRAIN: if (!busy) begin
                    state         <= DONE;
                    bus.res_valid <= 1'b1;
                end
                DONE: if (bus.res_ready) begin
                    state         <= IDLE;
                    bus.res_valid <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag delay line so each pair's shift/sign meets its row sums from memory plus mvp pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < PR + 2; k++) tp[k] <= '0;
        end else begin
            tp[0] <= ntag;
            for (int k = 1; k < PR + 2; k++) tp[k] <= tp[k-1];
        end
    end

    // Per-row accumulators: add or subtract the sign-extended, shifted row sum as each tag emerges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.res_data <= '0;
        end else if (accept) begin
            bus.res_data <= '0;
        end else if (tp[PR+1].v) begin
            for (int i = 0; i < N; i++)
                bus.res_data[i*ACCW +: ACCW] <= tp[PR+1].neg
                    ? bus.res_data[i*ACCW +: ACCW] - term(bus.mvp_s[i*SW +: SW], tp[PR+1].sh)
                    : bus.res_data[i*ACCW +: ACCW] + term(bus.mvp_s[i*SW +: SW], tp[PR+1].sh);
        end
    end
endmodule

// File: tb/tb_mvp_seq.sv
// tb_mvp_seq: vector table plus reset sequences, with plane memories and a popcount mvp model around the sequencer
module tb_mvp_seq;
    localparam int N = 4, PR = 1, AW = 10, ACCW = 24;
    localparam int A = $clog2(N), SW = A + 2, RW = N * ACCW;

    typedef struct {
        logic [3:0]    wp, ip;
        logic          ws, ds;
        logic [1:0]    mode;
        logic [AW-1:0] wbase, dbase;
        int            wval, dval, want, hold;
        bit            rnd;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b0;
    int tests = 0, fails = 0;
    logic [N*N-1:0]    wmem [1<<AW];
    logic [N-1:0]      dmem [1<<AW];
    logic [N*N-1:0]    wq;
    logic [N-1:0]      dq;
    logic [N*SW-1:0]   s_comb, s_reg;
    logic [RW-1:0]     rq [$];
    logic [2*AW-1:0]   aq [$];
    vec_t tbl [11];

    mvp_seq_if #(.N(N), .AW(AW), .ACCW(ACCW)) bus ();
    mvp_seq #(.N(N), .PR(PR), .AW(AW), .ACCW(ACCW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    // Plane memories with one-cycle read latency
    always @(posedge clk) begin
        if (bus.w_rd_en) wq <= wmem[bus.w_addr];
        if (bus.d_rd_en) dq <= dmem[bus.d_addr];
        s_reg <= s_comb;
    end

    // mvp model: row popcount of weights AND data, negated in mode 3 so negative sums occur
    always_comb begin
        s_comb = '0;
        for (int i = 0; i < N; i++) begin
            int pc;
            pc = $countones(wq[i*N +: N] & dq);
            s_comb[i*SW +: SW] = SW'(bus.mvp_mode == 2'd3 ? -pc : pc);
        end
    end
    assign bus.mvp_s = PR == 0 ? s_comb : s_reg;

    task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int eff(input logic [3:0] p);
        return p == 4'd0 ? 1 : p > 4'd8 ? 8 : int'(p);
    endfunction

    // Reference: rebuild each matrix element and data word from the stored planes, then take the product
    function automatic logic [RW-1:0] model(input vec_t v, input int wp, input int ip);
        logic [RW-1:0] e = '0;
        logic [AW-1:0] a;
        for (int i = 0; i < N; i++) begin
            int acc = 0;
            for (int j = 0; j < N; j++) begin
                int w = 0, d = 0;
                for (int k = 0; k < wp; k++) begin
                    a = AW'(int'(v.wbase) + k);
                    if (wmem[a][i*N+j]) w += (v.ws && k == wp - 1) ? -(1 << k) : (1 << k);
                end
                for (int k = 0; k < ip; k++) begin
                    a = AW'(int'(v.dbase) + k);
                    if (dmem[a][j]) d += (v.ds && k == ip - 1) ? -(1 << k) : (1 << k);
                end
                acc += w * d;
            end
            if (v.mode == 2'd3) acc = -acc;
            e[i*ACCW +: ACCW] = ACCW'(acc);
        end
        return e;
    endfunction

    // Read-address scoreboard: every strobe must match the next expected (weight, data) address pair
    always @(negedge clk) begin
        if (rst_n && bus.w_rd_en) begin
            chk("d_rd_en", RW'(bus.d_rd_en), RW'(1));
            if (aq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL read addr: got %0h with no read pending", {bus.w_addr, bus.d_addr});
            end else begin
                chk("read addr", RW'({bus.w_addr, bus.d_addr}), RW'(aq.pop_front()));
            end
        end
    end

    task automatic start_job(input vec_t v);
        int wp, ip;
        logic [RW-1:0] e;
        logic [AW-1:0] a;
        wp = eff(v.wp);
        ip = eff(v.ip);
        for (int k = 0; k < wp; k++) begin
            a = AW'(int'(v.wbase) + k);
            if (v.rnd) wmem[a] = (N*N)'($urandom);
            else wmem[a] = ((v.wval >> k) & 1) != 0 ? {(N*N){1'b1}} : '0;
        end
        for (int k = 0; k < ip; k++) begin
            a = AW'(int'(v.dbase) + k);
            if (v.rnd) dmem[a] = N'($urandom);
            else dmem[a] = ((v.dval >> k) & 1) != 0 ? {N{1'b1}} : '0;
        end
        if (v.rnd) e = model(v, wp, ip);
        else for (int i = 0; i < N; i++) e[i*ACCW +: ACCW] = ACCW'(v.want);
        rq.push_back(e);
        for (int w = wp - 1; w >= 0; w--)
            for (int d = ip - 1; d >= 0; d--)
                aq.push_back({AW'(int'(v.wbase) + w), AW'(int'(v.dbase) + d)});
        chk("cmd_ready idle", RW'(bus.cmd_ready), RW'(1));
        bus.cmd_wprec   = v.wp;
        bus.cmd_iprec   = v.ip;
        bus.cmd_wsigned = v.ws;
        bus.cmd_dsigned = v.ds;
        bus.cmd_mode    = v.mode;
        bus.cmd_wbase   = v.wbase;
        bus.cmd_dbase   = v.dbase;
        bus.cmd_valid   = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        chk("mvp_mode", RW'(bus.mvp_mode), RW'(v.mode));
        chk("cmd_ready busy", RW'(bus.cmd_ready), RW'(0));
    endtask

    task automatic finish_job(input vec_t v);
        int cyc = 0;
        logic [RW-1:0] snap, e;
        while (!bus.res_valid && cyc < 400) begin
            step();
            cyc++;
        end
        chk("latency", RW'(cyc), RW'(eff(v.wp) * eff(v.ip) + 1 + PR));
        snap = bus.res_data;
        for (int h = 0; h < v.hold; h++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_wprec = 4'($urandom);
            bus.cmd_iprec = 4'($urandom);
            bus.cmd_mode  = 2'($urandom);
            step();
            chk("hold res_valid", RW'(bus.res_valid), RW'(1));
            chk("hold res_data", bus.res_data, snap);
            chk("hold cmd_ready", RW'(bus.cmd_ready), RW'(0));
            chk("hold mvp_mode", RW'(bus.mvp_mode), RW'(v.mode));
        end
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        chk("res_valid drop", RW'(bus.res_valid), RW'(0));
        chk("cmd_ready rise", RW'(bus.cmd_ready), RW'(1));
        chk("no read after handoff", RW'(bus.w_rd_en), RW'(0));
        bus.cmd_valid = 1'b0;
        e = rq.size() != 0 ? rq.pop_front() : '0;
        chk("result", snap, e);
        chk("reads left", RW'(aq.size()), RW'(0));
    endtask

    task automatic run_job(input vec_t v);
        start_job(v);
        finish_job(v);
    endtask

    task automatic do_reset(input string where);
        rst_n = 1'b0;
        #1;
        chk({where, " cmd_ready"}, RW'(bus.cmd_ready), RW'(1));
        chk({where, " res_valid"}, RW'(bus.res_valid), RW'(0));
        chk({where, " rd_en"}, RW'({bus.w_rd_en, bus.d_rd_en}), RW'(0));
        chk({where, " addr"}, RW'({bus.w_addr, bus.d_addr}), RW'(0));
        chk({where, " mvp_mode"}, RW'(bus.mvp_mode), RW'(0));
        chk({where, " res_data"}, bus.res_data, '0);
        aq.delete();
        rq.delete();
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Main sequence: reset, table vectors, random jobs, then reset in every state
    initial begin
        vec_t r;
        int c;
        bus.cmd_valid = 1'b0;
        bus.cmd_wprec = '0;
        bus.cmd_iprec = '0;
        bus.cmd_wbase = '0;
        bus.cmd_dbase = '0;
        bus.cmd_wsigned = 1'b0;
        bus.cmd_dsigned = 1'b0;
        bus.cmd_mode = '0;
        bus.res_ready = 1'b0;
        tbl[0]  = '{4'd1,  4'd1,  1'b0, 1'b0, 2'd0, 10'd10,   10'd20,  1,    1,    4,       0,  1'b0};
        tbl[1]  = '{4'd2,  4'd3,  1'b0, 1'b0, 2'd1, 10'd30,   10'd40,  3,    5,    60,      10, 1'b0};
        tbl[2]  = '{4'd2,  4'd2,  1'b1, 1'b1, 2'd2, 10'd50,   10'd60,  -1,   -2,   8,       0,  1'b0};
        tbl[3]  = '{4'd2,  4'd2,  1'b1, 1'b0, 2'd0, 10'd70,   10'd80,  -1,   2,    -8,      0,  1'b0};
        tbl[4]  = '{4'd0,  4'd12, 1'b0, 1'b0, 2'd0, 10'd100,  10'd200, 1,    200,  800,     0,  1'b0};
        tbl[5]  = '{4'd2,  4'd1,  1'b0, 1'b0, 2'd0, 10'd1023, 10'd300, 3,    1,    12,      0,  1'b0};
        tbl[6]  = '{4'd8,  4'd8,  1'b1, 1'b1, 2'd0, 10'd400,  10'd500, -128, -128, 65536,   0,  1'b0};
        tbl[7]  = '{4'd8,  4'd8,  1'b1, 1'b0, 2'd3, 10'd600,  10'd700, -128, 255,  130560,  2,  1'b0};
        tbl[8]  = '{4'd3,  4'd4,  1'b1, 1'b0, 2'd0, 10'd5,    10'd6,   -3,   9,    -108,    0,  1'b0};
        tbl[9]  = '{4'd5,  4'd2,  1'b0, 1'b1, 2'd3, 10'd7,    10'd8,   17,   -1,   68,      0,  1'b0};
        tbl[10] = '{4'd15, 4'd1,  1'b0, 1'b0, 2'd0, 10'd900,  10'd910, 255,  1,    1020,    0,  1'b0};
        repeat (2) @(posedge clk);
        #1;
        do_reset("reset at start");
        for (int t = 0; t < 11; t++) run_job(tbl[t]);
        for (int t = 0; t < 4; t++) begin
            r.wp = 4'($urandom_range(0, 10));
            r.ip = 4'($urandom_range(0, 10));
            r.ws = 1'($urandom);
            r.ds = 1'($urandom);
            r.mode = $urandom_range(0, 1) != 0 ? 2'd3 : 2'd0;
            r.wbase = AW'($urandom);
            r.dbase = AW'($urandom);
            r.wval = 0;
            r.dval = 0;
            r.want = 0;
            r.hold = 0;
            r.rnd = 1'b1;
            run_job(r);
        end
        do_reset("reset in idle");
        run_job(tbl[2]);
        start_job(tbl[7]);
        repeat (5) step();
        do_reset("reset in run");
        run_job(tbl[1]);
        start_job(tbl[9]);
        repeat (10) step();
        do_reset("reset in drain");
        run_job(tbl[3]);
        start_job(tbl[9]);
        c = 0;
        while (!bus.res_valid && c < 100) begin
            step();
            c++;
        end
        chk("reach done", RW'(bus.res_valid), RW'(1));
        repeat (3) step();
        do_reset("reset in done");
        run_job(tbl[0]);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mvp_seq.md
Name: mvp_seq

Overview:
- Bit-serial precision sequencer for the mvp binary matrix-vector array.
- Accepts one command per job (weight/data precision, plane base addresses, signedness, mode) and walks every (weight bit-plane, data bit-plane) pair through mvp, one pair per cycle.
- Shifts, signs and accumulates the per-row partial sums into N accumulators, then presents the multi-bit result on a valid/ready port.
- Sits between the weight/data plane memories and the downstream result consumer.

Parameters:
- N, 64, rows/columns of mvp; A = clog2(N); mvp row sum width is A+2, signed.
- PR, 0, mvp pipeline depth in cycles (0 = combinational).
- AW, 10, plane memory address width.
- ACCW, 24, accumulator width per row, two's complement.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_wprec  in  4  weight precision in bits (1..8).
- cmd_iprec  in  4  data precision in bits (1..8).
- cmd_wbase  in  AW  address of weight plane 0 (LSB plane); plane k at wbase+k.
- cmd_dbase  in  AW  address of data plane 0; plane k at dbase+k.
- cmd_wsigned  in  1  weight MSB plane has negative weight.
- cmd_dsigned  in  1  data MSB plane has negative weight.
- cmd_mode  in  2  mode driven to mvp for whole job.
- w_rd_en  out  1  weight memory read strobe; data returns next cycle.
- w_addr  out  AW  weight plane address.
- d_rd_en  out  1  data memory read strobe; data returns next cycle.
- d_addr  out  AW  data plane address.
- mvp_mode  out  2  registered cmd_mode.
- mvp_s  in  N*(A+2)  row sums from mvp; row i at [i*(A+2) +: A+2].
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts.
- res_data  out  N*ACCW  accumulators; row i at [i*ACCW +: ACCW].

Behaviour:
- Reset (async, any state): IDLE; cmd_ready=1; res_valid=0; w_rd_en=d_rd_en=0; addresses=0; mvp_mode=0; all accumulators=0; tag pipeline cleared. Reset mid-job discards the job silently.
- Precision fields: 0 is treated as 1; 9..15 saturate to 8.
- IDLE:
  - On cmd_valid & cmd_ready, latch all fields and clear accumulators.
  - Set wb=wprec-1, db=iprec-1, then go to RUN.
- RUN, each cycle:
  - Assert w_rd_en/d_rd_en with w_addr=wbase+wb, d_addr=dbase+db.
  - Push a tag {valid, shift=wb+db, neg} into a delay line of 1+PR stages.
  - neg = (wsigned & wb==wprec-1) XOR (dsigned & db==iprec-1).
  - Iteration order: db decrements fastest; on db=0, reset db to iprec-1 and decrement wb.
  - After issuing pair (0,0), go to DRAIN.
  - Total issue cycles = wprec*iprec.
- Address wrap: base+k computed modulo 2^AW.
- Accumulate when the tag emerges (1+PR cycles after issue): for every row, sign-extend mvp_s row to ACCW, shift left by tag.shift, then add, or subtract if tag.neg. Result is modulo 2^ACCW; no saturation.
- DRAIN: no reads issued; when the last tag has accumulated, go to DONE.
- Issue-to-result latency = wprec*iprec + 1 + PR cycles from the cycle after acceptance.
- DONE:
  - res_valid=1 and res_data holds stable.
  - On res_valid & res_ready, go to IDLE with res_valid=0 next cycle. cmd_ready rises that same next cycle.
  - A new command is not accepted in the handoff cycle.
- cmd_valid outside IDLE is ignored (cmd_ready=0); no back-pressure toward mvp or memories.
- mvp_mode changes only on command acceptance.

Test Plan:
- Reset in each state (IDLE, mid-RUN, DRAIN, DONE with res_ready=0) -> all outputs at reset values immediately; next command runs cleanly.
- N=4, PR=0, wprec=iprec=1, unsigned, all-ones weights and data (mvp_s row=4) -> w_addr/d_addr = bases for 1 cycle; res_valid 2 cycles after accept; each row = 4.
- N=4, PR=1, wprec=2, iprec=3, unsigned, weight value 3 (planes all-ones), data value 5 (planes 1,0,1 all-ones):
  - Read order (wb,db) = (1,2),(1,1),(1,0),(0,2),(0,1),(0,0).
  - Each row = 4*3*5 = 60.
  - res_valid at cycle 6+2 after accept.
- Signed case with N=4, PR=0, wsigned=1, dsigned=1, wprec=iprec=2, weight -1 (11), data -2 (10) -> each row = 4*(-1)*(-2) = 8. Repeat with dsigned=0 and data 2 -> -8.
- Back-pressure: hold res_ready=0 for 10 cycles -> res_valid and res_data stable, cmd_ready=0, cmd_valid ignored. Release -> res_valid falls next cycle, cmd_ready rises the same cycle.
- Boundaries:
  - wprec=0 and iprec=12 behave as 1 and 8: 8 reads, shifts 0..7.
  - wbase=2^AW-1 with wprec=2 -> second weight address wraps to 0.
